// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: time-multiplexed scan controller for a 4-digit BCD display
// sharing one BCD-to-7-segment decoder. Each digit slot is SLOT_CYC cycles:
// one BLANK cycle (decoder held in reset, all digits dark), then SLOT_CYC-1
// DRIVE cycles with the active digit's value and its one-cold select.
// Ports:
//   clk, Reset_n            : clock, synchronous active-low reset
//   en                      : scan enable; dropping it abandons the frame
//   load_valid/load_data    : offer a new {d3,d2,d1,d0} word
//   load_ready              : pending buffer empty
//   lamp_test, blank_lz     : decoder preset / leading-zero suppression
//   err_clr                 : clears the sticky bcd_err flag
//   dec_in, dec_preset,
//   dec_reset_n             : shared decoder controls
//   dig_en_n                : one-cold digit select
//   frame_done              : pulse on the last drive cycle of digit 3
//   bcd_err                 : sticky, a digit > 9 was driven
module bcd_scan_ctrl #(
    parameter int unsigned SLOT_CYC = 8
) (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic        en,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    input  logic        lamp_test,
    input  logic        blank_lz,
    input  logic        err_clr,
    output logic [3:0]  dec_in,
    output logic        dec_preset,
    output logic        dec_reset_n,
    output logic [3:0]  dig_en_n,
    output logic        frame_done,
    output logic        bcd_err
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned WORD_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [WORD_W-1:0]   active, active_nxt;
    logic [WORD_W-1:0]   pending, pending_nxt;
    logic                full, full_nxt;

    logic                load_ready_nxt;
    logic [DIG_W-1:0]    dec_in_nxt;
    logic                dec_preset_nxt;
    logic                dec_reset_n_nxt;
    logic [3:0]          dig_en_n_nxt;
    logic                frame_done_nxt;
    logic                bcd_err_nxt;

    logic                xfer_c;
    logic                accept_c;
    logic [DIG_W-1:0]    digit_c;
    logic [3:0]          lz_mask_c;
    logic                suppress_c;
    logic                err_set_c;

    // Next-state, buffer and output decode. Outputs are decoded from the
    // next state so the registered outputs line up with the state they show.
    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        cnt_nxt         = cnt;
        active_nxt      = active;
        pending_nxt     = pending;
        full_nxt        = full;
        dec_in_nxt      = '0;
        dec_preset_nxt  = 1'b0;
        dec_reset_n_nxt = 1'b0;
        dig_en_n_nxt    = 4'hF;
        frame_done_nxt  = 1'b0;
        err_set_c       = 1'b0;

        // Frame-boundary transfer first; it only fires while full, when
        // load_ready is low, so it can never race a capture.
        xfer_c   = (state == BLANK) && (idx == '0) && full;
        accept_c = load_valid && load_ready;
        if (xfer_c) begin
            active_nxt = pending;
            full_nxt   = 1'b0;
        end
        if (accept_c) begin
            pending_nxt = load_data;
            full_nxt    = 1'b1;
        end

        if (!en) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
                BLANK: begin
                    state_nxt = DRIVE;
                    cnt_nxt   = CNT_W'(1);
                end
                DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = BLANK;
                        idx_nxt   = idx + IDX_W'(1);
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // lz_mask_c[k]: digits k..3 of the word being shown are all zero.
        digit_c      = active_nxt[{idx_nxt, 2'b00} +: DIG_W];
        lz_mask_c[3] = (active_nxt[15:12] == '0);
        lz_mask_c[2] = lz_mask_c[3] && (active_nxt[11:8] == '0);
        lz_mask_c[1] = lz_mask_c[2] && (active_nxt[7:4] == '0);
        lz_mask_c[0] = 1'b0;
        suppress_c   = blank_lz && !lamp_test && lz_mask_c[idx_nxt];

        if (state_nxt == DRIVE) begin
            dec_reset_n_nxt = 1'b1;
            dec_in_nxt      = digit_c;
            dec_preset_nxt  = lamp_test;
            if (!suppress_c) begin
                dig_en_n_nxt = ~(4'(4'b0001 << idx_nxt));
            end
            frame_done_nxt = (idx_nxt == IDX_W'(3)) && (cnt_nxt == CNT_LAST);
            err_set_c      = (cnt_nxt == CNT_W'(1)) && (digit_c > 4'd9);
        end

        // Set takes priority over clear.
        if (err_set_c) begin
            bcd_err_nxt = 1'b1;
        end else if (err_clr) begin
            bcd_err_nxt = 1'b0;
        end else begin
            bcd_err_nxt = bcd_err;
        end

        load_ready_nxt = !full_nxt;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            active      <= '0;
            pending     <= '0;
            full        <= 1'b0;
            load_ready  <= 1'b1;
            dec_in      <= '0;
            dec_preset  <= 1'b0;
            dec_reset_n <= 1'b0;
            dig_en_n    <= 4'hF;
            frame_done  <= 1'b0;
            bcd_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            cnt         <= cnt_nxt;
            active      <= active_nxt;
            pending     <= pending_nxt;
            full        <= full_nxt;
            load_ready  <= load_ready_nxt;
            dec_in      <= dec_in_nxt;
            dec_preset  <= dec_preset_nxt;
            dec_reset_n <= dec_reset_n_nxt;
            dig_en_n    <= dig_en_n_nxt;
            frame_done  <= frame_done_nxt;
            bcd_err     <= bcd_err_nxt;
        end
    end

endmodule

// File: doc/bcd_scan_ctrl.md
BCD_SCAN_CTRL -- requirements
Module: bcd_scan_ctrl

Interface
REQ-001 SHALL have parameter: SLOT_CYC, default 8, cycles per digit slot; legal range 2..255.
REQ-002 SHALL have port: clk  in  1  rising-edge clock for all state.
REQ-003 SHALL have port: Reset_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: en  in  1  scan enable.
REQ-005 SHALL have port: load_valid  in  1  new 4-digit BCD word offered.
REQ-006 SHALL have port: load_data  in  16  digits {d3,d2,d1,d0}, 4 bits each, d0 in [3:0].
REQ-007 SHALL have port: load_ready  out  1  pending buffer can accept a word.
REQ-008 SHALL have port: lamp_test  in  1  drive preset to the shared decoder during drive cycles.
REQ-009 SHALL have port: blank_lz  in  1  leading-zero suppression enable.
REQ-010 SHALL have port: err_clr  in  1  clear bcd_err.
REQ-011 SHALL have port: dec_in  out  4  BCD value to the shared decoder.
REQ-012 SHALL have port: dec_preset  out  1  decoder preset.
REQ-013 SHALL have port: dec_reset_n  out  1  decoder reset, active-low.
REQ-014 SHALL have port: dig_en_n  out  4  one-cold digit select; bit k selects digit k.
REQ-015 SHALL have port: frame_done  out  1  one-cycle pulse at end of digit-3 slot.
REQ-016 SHALL have port: bcd_err  out  1  sticky; a digit >9 was driven.

Function
REQ-017 SHALL register all outputs.
REQ-018 SHALL implement states IDLE, BLANK, DRIVE, plus digit index idx (0..3) and slot counter cnt (0..SLOT_CYC-1).
REQ-019 SHALL transition IDLE->BLANK when en=1, with idx=0 and cnt=0.
REQ-020 SHALL hold BLANK for exactly 1 cycle (cnt=0): dig_en_n=4'hF, dec_reset_n=0, dec_preset=0; then go to DRIVE.
REQ-021 SHALL hold DRIVE for SLOT_CYC-1 cycles: dec_reset_n=1, dec_in=active digit idx, dig_en_n bit idx=0 and all other bits 1.
REQ-022 SHALL, at end of DRIVE, set idx=(idx+1) mod 4 and go to BLANK; when idx was 3, pulse frame_done in that same cycle.
REQ-023 SHALL, when en=0 in any state, go to IDLE next cycle: dig_en_n=4'hF, dec_reset_n=0, idx=0, cnt=0; the current frame is abandoned and frame_done is not pulsed.
REQ-024 SHALL keep a 16-bit pending buffer with a full flag; load_ready = NOT full (registered).
REQ-025 SHALL accept a word on load_valid&&load_ready, capturing it into pending and setting full.
REQ-026 SHALL, on every BLANK cycle with idx=0 and full=1, copy pending to the active register and clear full; digits never change mid-frame.
REQ-027 SHALL apply the REQ-026 transfer before REQ-025 capture when both occur in one cycle; load_ready=0 that cycle guarantees no overwrite of untransferred data.
REQ-028 SHALL, in DRIVE with lamp_test=1, drive dec_preset=1 and ignore blank_lz; all digits are enabled in turn.
REQ-029 SHALL, with blank_lz=1 and lamp_test=0, keep dig_en_n=4'hF during DRIVE of digit k (k=3..1) when active digits k..3 are all 0; digit 0 is never suppressed.
REQ-030 SHALL set bcd_err on the first DRIVE cycle of any digit with value >9, whether or not it is suppressed; dec_in still carries the raw value.
REQ-031 SHALL clear bcd_err on err_clr=1; a simultaneous set wins.
REQ-032 SHALL make lamp_test, blank_lz and load acceptance independent of en.

Reset
REQ-033 SHALL, on Reset_n=0 at a clock edge: state=IDLE, idx=0, cnt=0, active=16'h0000, pending empty, load_ready=1, dig_en_n=4'hF, dec_in=0, dec_preset=0, dec_reset_n=0, frame_done=0, bcd_err=0.
REQ-034 SHALL let reset override all other inputs, including mid-slot and mid-load.

Verification
REQ-035 SHALL cover: reset, load 16'h1234, en=1, SLOT_CYC=8 -> per slot: 1 blank cycle, then 7 cycles with dig_en_n=1110/dec_in=4, 1101/3, 1011/2, 0111/1; frame_done at cycle 32 after the first BLANK.
REQ-036 SHALL cover: blank_lz=1 with word 16'h0050 -> digits 3 and 2 dark, digits 1 (5) and 0 (0) lit; lamp_test=1 -> all four lit with dec_preset=1.
REQ-037 SHALL cover: two back-to-back loads during one frame -> second sees load_ready=0 until the next idx=0 BLANK; active word switches only at the frame boundary.
REQ-038 SHALL cover: word 16'h00A0 -> bcd_err=1 at first DRIVE of digit 1, held until err_clr; err_clr coincident with a new set -> remains 1.
REQ-039 SHALL cover: en dropped mid-DRIVE of digit 2 -> next cycle dig_en_n=4'hF, dec_reset_n=0, no frame_done; re-enable restarts at digit 0.
REQ-040 SHALL cover: Reset_n=0 mid-frame with pending full -> all REQ-033 values on the next edge; load_ready=1.
